// File: rtl/bcd_pkg.sv
// bcd_pkg
// Shared definitions for the decimal front-panel path: conversion state
// encoding, BCD digit limits and a digit legality helper. The binary-to-BCD
// display divider uses this package as well, so everything here is
// independent of either converter's datapath width.
//
// Contents:
//    bcd_state_t  conversion sequencer states (idle, then one per digit)
//    BCD_MAX      largest legal BCD digit value
//    BCD_DIGITS   number of digits handled per conversion
//    is_bcd()     returns 1 when a 4-bit nibble holds a legal BCD digit

package bcd_pkg;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_D3   = 3'd1,
      S_D2   = 3'd2,
      S_D1   = 3'd3,
      S_D0   = 3'd4
   } bcd_state_t;

   localparam logic [3:0] BCD_MAX    = 4'd9;
   localparam int         BCD_DIGITS = 4;

   // A nibble is legal BCD when it does not exceed nine.
   function automatic logic is_bcd(input logic [3:0] digit);
      return (digit <= BCD_MAX);
   endfunction

endpackage

// File: rtl/bcd_digit_mac.sv
// bcd_digit_mac
// One Horner step for decimal-to-binary conversion: out16 = in16*10 + digit4.
// The multiply by ten is built from two shifts, (x<<3) + (x<<1), so no
// multiplier is needed. Everything is 16 bits wide and wraps modulo 2^16;
// legal four-digit inputs never come close to wrapping.
//
// Ports:
//    in16    in   16  running accumulator
//    digit4  in    4  next decimal digit, zero-extended before the add
//    out16   out  16  in16*10 + digit4

module bcd_digit_mac (
   input  logic [15:0] in16,
   input  logic [3:0]  digit4,
   output logic [15:0] out16
);

   logic [15:0] times8;
   logic [15:0] times2;

   assign times8 = in16 << 3;
   assign times2 = in16 << 1;

   // Sum of the two shifted copies gives in16*10, then the digit is added.
   assign out16 = times8 + times2 + {12'd0, digit4};

endmodule

// File: rtl/input_combiner.sv
// input_combiner
// Sequential BCD-to-binary converter for the front-panel input path. A start
// pulse latches four packed BCD digits, then Horner's rule is applied one
// digit per clock, most significant digit first. The 16-bit result appears on
// data together with a one-cycle valid pulse four cycles after the accepting
// edge. It is the input-side counterpart of the binary-to-BCD display divider.
//
// Optional feature (macro INPUT_COMBINER_CHECK_EN):
//    When defined, digits above nine are flagged at acceptance. The conversion
//    still takes the full four cycles, but the completed result reports
//    error=1 and data=0. When undefined, no digit checking exists, error is
//    held at 0 and out-of-range digits simply feed the arithmetic.
//
// Ports:
//    clk    in   1   system clock, rising-edge active
//    rst    in   1   asynchronous active-high reset, clears all state
//    start  in   1   conversion request, only sampled while idle
//    bcd0   in   4   ones digit
//    bcd1   in   4   tens digit
//    bcd2   in   4   hundreds digit
//    bcd3   in   4   thousands digit
//    data   out  16  converted value, held until the next completion
//    valid  out  1   one-cycle pulse marking a new data value
//    busy   out  1   high while a conversion is in flight
//    error  out  1   digit-range error, qualified by valid

module input_combiner
   import bcd_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [3:0]  bcd0,
   input  logic [3:0]  bcd1,
   input  logic [3:0]  bcd2,
   input  logic [3:0]  bcd3,
   output logic [15:0] data,
   output logic        valid,
   output logic        busy,
   output logic        error
);

   bcd_state_t  state;
   logic [3:0]  dig3;
   logic [3:0]  dig2;
   logic [3:0]  dig1;
   logic [3:0]  dig0;
   logic [15:0] acc;
   logic [3:0]  mac_digit;
   logic [15:0] mac_out;

`ifdef INPUT_COMBINER_CHECK_EN
   logic        bad;
   logic        any_illegal;

   // Any latched digit above nine poisons the whole conversion.
   assign any_illegal = !is_bcd(bcd3) || !is_bcd(bcd2) ||
                        !is_bcd(bcd1) || !is_bcd(bcd0);
`else
   assign error = 1'b0;
`endif

   // The single shared multiply-accumulate unit sees whichever digit the
   // current state is consuming. In idle its output is unused, so zero is fed.
   always_comb begin
      mac_digit = 4'd0;
      case (state)
         S_D3:    mac_digit = dig3;
         S_D2:    mac_digit = dig2;
         S_D1:    mac_digit = dig1;
         S_D0:    mac_digit = dig0;
         default: mac_digit = 4'd0;
      endcase
   end

   bcd_digit_mac u_mac (
      .in16   (acc),
      .digit4 (mac_digit),
      .out16  (mac_out)
   );

   // Conversion sequencer. Digits are captured only on acceptance so the
   // panel inputs may change freely while busy. acc starts at zero, so the
   // first step simply loads the thousands digit. The final step writes
   // straight into data instead of acc, which keeps the result stable
   // until the next completion. valid defaults low every cycle so it can
   // only ever be a single-cycle pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
         dig3  <= 4'd0;
         dig2  <= 4'd0;
         dig1  <= 4'd0;
         dig0  <= 4'd0;
         acc   <= 16'd0;
         data  <= 16'd0;
         valid <= 1'b0;
`ifdef INPUT_COMBINER_CHECK_EN
         bad   <= 1'b0;
         error <= 1'b0;
`endif
      end else begin
         valid <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  dig3  <= bcd3;
                  dig2  <= bcd2;
                  dig1  <= bcd1;
                  dig0  <= bcd0;
                  acc   <= 16'd0;
`ifdef INPUT_COMBINER_CHECK_EN
                  bad   <= any_illegal;
`endif
                  state <= S_D3;
               end
            end
            S_D3: begin
               acc   <= mac_out;
               state <= S_D2;
            end
            S_D2: begin
               acc   <= mac_out;
               state <= S_D1;
            end
            S_D1: begin
               acc   <= mac_out;
               state <= S_D0;
            end
            S_D0: begin
`ifdef INPUT_COMBINER_CHECK_EN
               data  <= bad ? 16'd0 : mac_out;
               error <= bad;
`else
               data  <= mac_out;
`endif
               valid <= 1'b1;
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   // Busy follows directly from the state register, so it has no input path.
   assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_input_combiner.sv
// tb_input_combiner
// Scoreboard bench for input_combiner. The driver applies one input vector
// per clock and keeps a simple model of the converter: a start seen while
// the model is free is accepted, the expected decimal value of the four
// digits is queued with the cycle on which valid must appear, and the model
// then stays busy for four edges. A separate monitor samples the DUT on the
// falling edge, pops and compares whenever valid is high, and also checks
// busy and the held data value every cycle.
// Expected error follows the INPUT_COMBINER_CHECK_EN macro, matching the
// build of the design under test.

module tb_input_combiner;

   typedef struct {
      logic [15:0] data;
      logic        err;
      int          due;
   } exp_t;

   logic        clk;
   logic        rst;
   logic        start;
   logic [3:0]  bcd0;
   logic [3:0]  bcd1;
   logic [3:0]  bcd2;
   logic [3:0]  bcd3;
   logic [15:0] data;
   logic        valid;
   logic        busy;
   logic        error;

   int          checks;
   int          errors;
   int          cycle;
   int          busy_left;
   logic [15:0] held_data;
   exp_t        sb[$];

   input_combiner dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .bcd0  (bcd0),
      .bcd1  (bcd1),
      .bcd2  (bcd2),
      .bcd3  (bcd3),
      .data  (data),
      .valid (valid),
      .busy  (busy),
      .error (error)
   );

   // Free-running clock, 10 time units per period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Compare one observed value with its expected value and log any miss.
   task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, cycle, act, exp);
      end
   endtask

   // Reference model: plain decimal place values, optionally poisoned by an
   // out-of-range digit when the range check is built in.
   function automatic exp_t modelResult(input logic [3:0] a, input logic [3:0] b,
                                        input logic [3:0] c, input logic [3:0] d,
                                        input int due);
      exp_t r;
      int   value;
      logic illegal;
      value   = int'(a) * 1000 + int'(b) * 100 + int'(c) * 10 + int'(d);
      illegal = (a > 4'd9) || (b > 4'd9) || (c > 4'd9) || (d > 4'd9);
      r.due   = due;
`ifdef INPUT_COMBINER_CHECK_EN
      r.data  = illegal ? 16'd0 : 16'(value % 65536);
      r.err   = illegal;
`else
      r.data  = 16'(value % 65536);
      r.err   = 1'b0;
`endif
      return r;
   endfunction

   // Drive one input vector for one clock and advance the model across the edge.
   task automatic applyStimulus(input logic s, input logic [3:0] a, input logic [3:0] b,
                                input logic [3:0] c, input logic [3:0] d);
      @(negedge clk);
      start = s;
      bcd3  = a;
      bcd2  = b;
      bcd1  = c;
      bcd0  = d;
      @(posedge clk);
      cycle++;
      if (busy_left == 0 && s) begin
         sb.push_back(modelResult(a, b, c, d, cycle + 4));
         busy_left = 4;
      end else if (busy_left > 0) begin
         busy_left--;
      end
   endtask

   // Run idle cycles with no start request.
   task automatic idleCycles(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, 4'd0, 4'd0, 4'd0, 4'd0);
   endtask

   // Assert reset between clock edges and confirm the outputs clear at once.
   task automatic resetAsync();
      #2 rst = 1'b1;
      #1;
      checkOutput("rst_data", data, 16'd0);
      checkOutput("rst_valid", {15'd0, valid}, 16'd0);
      checkOutput("rst_busy", {15'd0, busy}, 16'd0);
      checkOutput("rst_error", {15'd0, error}, 16'd0);
      sb.delete();
      busy_left = 0;
      held_data = 16'd0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Monitor: every falling edge check busy and the held data value; on a
   // valid pulse pop the oldest expectation and compare value, flag and
   // timing. A due result with no valid pulse counts as a miss.
   always @(negedge clk) begin
      if (!rst) begin
         checkOutput("busy", {15'd0, busy}, {15'd0, busy_left > 0});
         if (valid) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL unexpected_valid at cycle %0d: got data %0d, expected no pulse", cycle, data);
            end else begin
               exp_t e;
               e = sb.pop_front();
               held_data = e.data;
               checkOutput("data", data, e.data);
               checkOutput("error", {15'd0, error}, {15'd0, e.err});
               checkOutput("latency_cycle", 16'(cycle), 16'(e.due));
            end
         end else begin
            checkOutput("held_data", data, held_data);
            if (sb.size() != 0 && sb[0].due <= cycle) begin
               exp_t e;
               e = sb.pop_front();
               checks++;
               errors++;
               $display("[TB] FAIL missing_valid at cycle %0d: got no pulse, expected data %0d", cycle, e.data);
            end
         end
      end
   end

   // Directed scenarios first, then randomized traffic, then a drain check.
   initial begin
      logic [3:0] r3, r2, r1, r0;
      checks    = 0;
      errors    = 0;
      cycle     = 0;
      busy_left = 0;
      held_data = 16'd0;
      rst       = 1'b1;
      start     = 1'b0;
      bcd0      = 4'd0;
      bcd1      = 4'd0;
      bcd2      = 4'd0;
      bcd3      = 4'd0;

      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset_data", data, 16'd0);
      checkOutput("reset_valid", {15'd0, valid}, 16'd0);
      checkOutput("reset_busy", {15'd0, busy}, 16'd0);
      checkOutput("reset_error", {15'd0, error}, 16'd0);
      @(negedge clk);
      rst = 1'b0;

      applyStimulus(1'b1, 4'd1, 4'd2, 4'd3, 4'd4);
      idleCycles(6);

      applyStimulus(1'b1, 4'd9, 4'd9, 4'd9, 4'd9);
      idleCycles(5);
      applyStimulus(1'b1, 4'd0, 4'd0, 4'd0, 4'd0);
      idleCycles(5);

      for (int i = 0; i < 15; i++) applyStimulus(1'b1, 4'd0, 4'd0, 4'd4, 4'd2);
      idleCycles(6);

      applyStimulus(1'b1, 4'd0, 4'd0, 4'd0, 4'd7);
      applyStimulus(1'b0, 4'd0, 4'd0, 4'd0, 4'd7);
      applyStimulus(1'b1, 4'd8, 4'd8, 4'd8, 4'd8);
      applyStimulus(1'b0, 4'd8, 4'd8, 4'd8, 4'd8);
      idleCycles(4);

      applyStimulus(1'b1, 4'd5, 4'd6, 4'd7, 4'd8);
      applyStimulus(1'b0, 4'd0, 4'd0, 4'd0, 4'd0);
      resetAsync();
      idleCycles(6);
      applyStimulus(1'b1, 4'd0, 4'd0, 4'd1, 4'd0);
      idleCycles(6);

      applyStimulus(1'b1, 4'd1, 4'hA, 4'd0, 4'd0);
      idleCycles(6);

      for (int i = 0; i < 120; i++) begin
         r3 = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
         r2 = 4'($urandom_range(0, 9));
         r1 = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
         r0 = 4'($urandom_range(0, 9));
         applyStimulus(($urandom_range(0, 2) == 0), r3, r2, r1, r0);
      end

      idleCycles(8);
      checkOutput("scoreboard_empty", 16'(sb.size()), 16'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
